button_step_gen: RTL and testbench

//  Turns a raw, bouncing push-button input into clean single-cycle step pulses

---
 rtl/button_step_gen_pkg.sv | 28 ++
 rtl/button_step_gen_debounce_filter.sv | 50 +++++
 rtl/button_step_gen.sv | 103 ++++++++++
 tb/tb_button_step_gen.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/button_step_gen_pkg.sv
// Shared definitions for the button step generator:
// FSM state encodings and elaboration-time width helpers.
package button_step_gen_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HOLD   = 2'd1,
        ST_REPEAT = 2'd2
    } state_e;

    // Ceiling log2, never below 1 so derived vectors keep a width.
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = 1;
        while (v < value) begin
            v = v * 2;
            r = r + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/button_step_gen_debounce_filter.sv
// Synchroniser chain plus debounce counter for one raw button.
// level only changes after the synchronised input has held steady.
module debounce_filter #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level
);
    import button_step_gen_pkg::*;

    localparam int CW = clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [CW-1:0]          r_cnt;
    logic                   r_level;
    logic                   w_sync_q;

    assign w_sync_q = r_sync[SYNC_STAGES-1];
    assign level    = r_level;

    // Shift the asynchronous button through the synchroniser chain.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], din};
        end
    end

    // Count consecutive disagreeing edges; flip level once the
    // disagreement is still present after DEBOUNCE_CYCLES counts.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt   <= '0;
            r_level <= 1'b0;
        end else if (w_sync_q == r_level) begin
            r_cnt <= '0;
        end else if (r_cnt == CNT_LAST) begin
            r_cnt   <= '0;
            r_level <= ~r_level;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/button_step_gen.sv
// Push-button to step-pulse converter: debounce, rising-edge
// detect, hold/auto-repeat FSM and a registered one-cycle step.
module button_step_gen #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int HOLD_CYCLES     = 64,
    parameter int REPEAT_CYCLES   = 16,
    parameter int REPEAT_EN       = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    output logic step,
    output logic btn_level
);
    import button_step_gen_pkg::*;

    localparam int TW = clog2(max2(HOLD_CYCLES, REPEAT_CYCLES));
    localparam logic [TW-1:0] HOLD_LAST = TW'(HOLD_CYCLES - 1);
    localparam logic [TW-1:0] REP_LAST  = TW'(REPEAT_CYCLES - 1);

    state_e        r_state;
    state_e        w_state_nxt;
    logic [TW-1:0] r_timer;
    logic [TW-1:0] w_timer_nxt;
    logic          r_step;
    logic          w_step_nxt;
    logic          r_level_d;
    logic          w_level;
    logic          w_rise;

    debounce_filter #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_filter (
        .clk   (clk),
        .rst   (rst),
        .din   (btn_in),
        .level (w_level)
    );

    assign w_rise    = w_level & ~r_level_d;
    assign step      = r_step;
    assign btn_level = w_level;

    // State, timer, step pulse and the delayed level for edge detect.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_timer   <= '0;
            r_step    <= 1'b0;
            r_level_d <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_timer   <= w_timer_nxt;
            r_step    <= w_step_nxt;
            r_level_d <= w_level;
        end
    end

    // Next state: release always wins, otherwise press/hold/repeat.
    always_comb begin
        w_state_nxt = r_state;
        w_timer_nxt = r_timer;
        w_step_nxt  = 1'b0;
        if (!w_level) begin
            w_state_nxt = ST_IDLE;
            w_timer_nxt = '0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (w_rise) begin
                        w_step_nxt  = 1'b1;
                        w_timer_nxt = '0;
                        w_state_nxt = ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (REPEAT_EN != 0 && r_timer == HOLD_LAST) begin
                        w_step_nxt  = 1'b1;
                        w_timer_nxt = '0;
                        w_state_nxt = ST_REPEAT;
                    end else begin
                        w_timer_nxt = r_timer + 1'b1;
                    end
                end
                ST_REPEAT: begin
                    if (r_timer == REP_LAST) begin
                        w_step_nxt  = 1'b1;
                        w_timer_nxt = '0;
                    end else begin
                        w_timer_nxt = r_timer + 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_timer_nxt = '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_button_step_gen.sv
// Directed bench for button_step_gen (SYNC=2, DEBOUNCE=4,
// HOLD=8, REPEAT=3) plus a REPEAT_EN=0 instance and a 4-bit counter.
module tb_button_step_gen;

    logic clk    = 1'b0;
    logic rst    = 1'b1;
    logic btn_in = 1'b0;
    logic btn2   = 1'b0;
    logic step;
    logic btn_level;
    logic step2;
    logic btn_level2;
    logic [3:0] cnt4;

    int cyc   = 0;
    int n_cmp = 0;
    int n_err = 0;
    int q[$];
    int q2[$];

    always #5 clk = ~clk;

    button_step_gen #(
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (4),
        .HOLD_CYCLES     (8),
        .REPEAT_CYCLES   (3),
        .REPEAT_EN       (1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_in    (btn_in),
        .step      (step),
        .btn_level (btn_level)
    );

    button_step_gen #(
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (4),
        .HOLD_CYCLES     (8),
        .REPEAT_CYCLES   (3),
        .REPEAT_EN       (0)
    ) dut_norep (
        .clk       (clk),
        .rst       (rst),
        .btn_in    (btn2),
        .step      (step2),
        .btn_level (btn_level2)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // Negedge consumer: logs step edges and runs the 4-bit counter.
    always @(negedge clk) begin
        if (step) q.push_back(cyc);
        if (step2) q2.push_back(cyc);
        if (rst) cnt4 <= 4'd0;
        else if (step) cnt4 <= cnt4 + 4'd1;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic release_btn();
        int w;
        w = 0;
        btn_in = 1'b0;
        while (btn_level !== 1'b0 && w < 30) begin
            tick(1);
            w++;
        end
        n_cmp++;
        if (btn_level !== 1'b0) begin
            n_err++;
            $display("FAIL release_timeout: btn_level=%b want 0", btn_level);
        end
        tick(4);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(3);
        n_cmp++;
        if (step !== 1'b0 || btn_level !== 1'b0) begin
            n_err++;
            $display("FAIL reset_out: step=%b level=%b want 0 0", step, btn_level);
        end
        rst = 1'b0;
        tick(6);
        n_cmp++;
        if (step !== 1'b0 || btn_level !== 1'b0 || q.size() != 0) begin
            n_err++;
            $display("FAIL idle_out: step=%b level=%b steps=%0d want 0 0 0",
                     step, btn_level, q.size());
        end
    endtask

    task automatic test_clean_hold();
        int f;
        int m;
        int got;
        int exp_e[7];
        m = q.size();
        btn_in = 1'b1;
        f = cyc + 1;
        tick(6);
        n_cmp++;
        if (btn_level !== 1'b0) begin
            n_err++;
            $display("FAIL level_early: got %b want 0 at F+5", btn_level);
        end
        tick(1);
        n_cmp++;
        if (btn_level !== 1'b1) begin
            n_err++;
            $display("FAIL level_rise: got %b want 1 at F+6", btn_level);
        end
        tick(24);
        btn_in = 1'b0;
        tick(1);
        exp_e = '{f + 7, f + 15, f + 18, f + 21, f + 24, f + 27, f + 30};
        n_cmp++;
        if (q.size() - m != 7) begin
            n_err++;
            $display("FAIL hold_count: got %0d steps want 7", q.size() - m);
        end
        for (int i = 0; i < 7; i++) begin
            got = (m + i < q.size()) ? q[m + i] : -1;
            n_cmp++;
            if (got != exp_e[i]) begin
                n_err++;
                $display("FAIL hold_step%0d: edge F+%0d want F+%0d",
                         i, got - f, exp_e[i] - f);
            end
        end
        tick(5);
        n_cmp++;
        if (btn_level !== 1'b1) begin
            n_err++;
            $display("FAIL level_fall_early: got %b want 1 at F+36", btn_level);
        end
        tick(1);
        n_cmp++;
        if (btn_level !== 1'b0) begin
            n_err++;
            $display("FAIL level_fall: got %b want 0 at F+37", btn_level);
        end
        m = q.size();
        tick(15);
        n_cmp++;
        if (q.size() != m) begin
            n_err++;
            $display("FAIL release_step: got %0d steps want 0", q.size() - m);
        end
    endtask

    task automatic test_glitch();
        int m;
        logic seen;
        m = q.size();
        seen = 1'b0;
        btn_in = 1'b1;
        tick(3);
        btn_in = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (btn_level !== 1'b0) seen = 1'b1;
        end
        n_cmp++;
        if (seen !== 1'b0 || q.size() != m) begin
            n_err++;
            $display("FAIL glitch: level_seen=%b steps=%0d want 0 0",
                     seen, q.size() - m);
        end
    endtask

    task automatic test_bounce();
        int f;
        int m;
        int got;
        m = q.size();
        for (int k = 0; k < 3; k++) begin
            btn_in = 1'b1;
            tick(2);
            btn_in = 1'b0;
            tick(2);
        end
        btn_in = 1'b1;
        f = cyc + 1;
        tick(12);
        n_cmp++;
        if (q.size() - m != 1) begin
            n_err++;
            $display("FAIL bounce_count: got %0d steps want 1", q.size() - m);
        end
        got = (m < q.size()) ? q[m] : -1;
        n_cmp++;
        if (got != f + 7) begin
            n_err++;
            $display("FAIL bounce_edge: edge F+%0d want F+7", got - f);
        end
        release_btn();
    endtask

    task automatic test_reset_mid_hold();
        int f;
        int m;
        int got;
        btn_in = 1'b1;
        f = cyc + 1;
        tick(17);
        rst = 1'b1;
        tick(1);
        n_cmp++;
        if (step !== 1'b0 || btn_level !== 1'b0) begin
            n_err++;
            $display("FAIL rst_mid_a: step=%b level=%b want 0 0", step, btn_level);
        end
        tick(1);
        n_cmp++;
        if (step !== 1'b0 || btn_level !== 1'b0) begin
            n_err++;
            $display("FAIL rst_mid_b: step=%b level=%b want 0 0", step, btn_level);
        end
        rst = 1'b0;
        m = q.size();
        tick(12);
        n_cmp++;
        if (q.size() - m != 1) begin
            n_err++;
            $display("FAIL rst_restart_count: got %0d steps want 1", q.size() - m);
        end
        got = (m < q.size()) ? q[m] : -1;
        n_cmp++;
        if (got != f + 26) begin
            n_err++;
            $display("FAIL rst_restart_edge: edge F+%0d want F+26", got - f);
        end
        release_btn();
    endtask

    task automatic test_no_repeat();
        int f;
        int m;
        int got;
        m = q2.size();
        btn2 = 1'b1;
        f = cyc + 1;
        tick(100);
        btn2 = 1'b0;
        tick(12);
        n_cmp++;
        if (q2.size() - m != 1) begin
            n_err++;
            $display("FAIL norep_count: got %0d steps want 1", q2.size() - m);
        end
        got = (m < q2.size()) ? q2[m] : -1;
        n_cmp++;
        if (got != f + 7) begin
            n_err++;
            $display("FAIL norep_edge: edge F+%0d want F+7", got - f);
        end
    endtask

    task automatic test_counter_wrap();
        logic [3:0] exp_c;
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(2);
        exp_c = 4'd0;
        for (int i = 0; i < 17; i++) begin
            btn_in = 1'b1;
            tick(8);
            btn_in = 1'b0;
            tick(12);
            exp_c = exp_c + 4'd1;
            n_cmp++;
            if (cnt4 !== exp_c) begin
                n_err++;
                $display("FAIL count_press%0d: got %0d want %0d", i, cnt4, exp_c);
            end
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_clean_hold();
        test_glitch();
        test_bounce();
        test_reset_mid_hold();
        test_no_repeat();
        test_counter_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
